pipeline_hazard_unit: RTL and testbench

- Parametrised hazard/forwarding controller for the in-order pipeline. It replaces the fixed 4-stage opcode-compare stall logic.
- It keeps its own scoreboard of destination metadata for every in-flight instruction past decode. Each cycle it compares the decode-stage instruction's sources against that scoreboard.
- It drives stall, bubble and per-operand forwarding selects to the datapath, and keeps a saturating stall counter for performance analysis.

---
 rtl/pipeline_pkg.sv | 47 ++++
 rtl/hazard_operand_match.sv | 41 ++++
 rtl/pipeline_hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard scoreboard entry, forwarding encoding
// and the opcode set decode uses to build its dec_* metadata.
package pipeline_pkg;

  localparam int HZ_RW_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [HZ_RW_MAX-1:0] rd;
    logic                 wr_reg;
    logic                 is_load;
    logic                 wr_nz;
  } hz_entry_t;

  localparam int FWD_RF = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MV  = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BCC = 4'h8;

  function automatic logic op_wr_reg(
    input logic [3:0] op
  );
    return op inside {OP_ADD, OP_SUB,
                      OP_MV, OP_LD};
  endfunction

  function automatic logic op_wr_nz(
    input logic [3:0] op
  );
    return op inside {OP_ADD, OP_SUB,
                      OP_CMP};
  endfunction

  function automatic logic op_rd_nz(
    input logic [3:0] op
  );
    return op == OP_BCC;
  endfunction

endpackage

// File: rtl/hazard_operand_match.sv
// Priority compare of one source operand against all in-flight slots.
// Ports: use/src in; cand/rd/is_load per slot in; hit/slot_idx/hit_load out.
module hazard_operand_match
  import pipeline_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int RW        = 3,
  parameter int SW        = 2
) (
  input  logic                 use_src,
  input  logic [RW-1:0]        src,
  input  logic [NUM_SLOTS:1]   cand,
  input  logic [NUM_SLOTS:1]
               [HZ_RW_MAX-1:0] rd,
  input  logic [NUM_SLOTS:1]   is_load,
  output logic                 hit,
  output logic [SW-1:0]        slot_idx,
  output logic                 hit_load
);

  logic [HZ_RW_MAX-1:0] src_x;

  assign src_x = HZ_RW_MAX'(src);

  // Scan oldest to youngest so the
  // youngest producer overwrites.
  always_comb begin
    hit      = 1'b0;
    slot_idx = SW'(FWD_RF);
    hit_load = 1'b0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      if (use_src && cand[k] &&
          rd[k] == src_x) begin
        hit      = 1'b1;
        slot_idx = SW'(k);
        hit_load = is_load[k];
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard-based stall/bubble/forwarding control for decode.
// Ports: clk, reset(n), dec_* in; stall, bubble, fwd_sel_a/b, stall_count out.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter  int NUM_REGS        = 8,
  parameter  int NUM_SLOTS       = 3,
  parameter  int FWD_EN          = 1,
  parameter  int LOAD_READY_SLOT = 2,
  parameter  int NZ_READY_SLOT   = 2,
  parameter  int CNT_W           = 16,
  localparam int RW = $clog2(NUM_REGS),
  localparam int SW = $clog2(NUM_SLOTS+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [RW-1:0]    dec_rs_a,
  input  logic [RW-1:0]    dec_rs_b,
  input  logic             dec_use_a,
  input  logic             dec_use_b,
  input  logic [RW-1:0]    dec_rd,
  input  logic             dec_wr_reg,
  input  logic             dec_is_load,
  input  logic             dec_wr_nz,
  input  logic             dec_rd_nz,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [SW-1:0]    fwd_sel_a,
  output logic [SW-1:0]    fwd_sel_b,
  output logic [CNT_W-1:0] stall_count
);

  hz_entry_t [NUM_SLOTS:1] slot_q;
  hz_entry_t [NUM_SLOTS:1] slot_d;
  hz_entry_t               dec_entry;

  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  logic [NUM_SLOTS:1] cand;
  logic [NUM_SLOTS:1] ld_vec;
  logic [NUM_SLOTS:1] nz_vec;
  logic [NUM_SLOTS:1] nz_mask;
  logic [NUM_SLOTS:1]
        [HZ_RW_MAX-1:0] rd_vec;

  logic          hit_a;
  logic          hit_b;
  logic          ld_a;
  logic          ld_b;
  logic [SW-1:0] idx_a;
  logic [SW-1:0] idx_b;

  logic raw_stall;
  logic nz_stall;
  logic issue;

  always_comb begin
    nz_mask = '0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      cand[k]    = slot_q[k].valid &
                   slot_q[k].wr_reg;
      ld_vec[k]  = slot_q[k].is_load;
      rd_vec[k]  = slot_q[k].rd;
      nz_vec[k]  = slot_q[k].valid &
                   slot_q[k].wr_nz;
      nz_mask[k] = (k < NZ_READY_SLOT);
    end
  end

  hazard_operand_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .RW        (RW),
    .SW        (SW)
  ) u_match_a (
    .use_src  (dec_use_a),
    .src      (dec_rs_a),
    .cand     (cand),
    .rd       (rd_vec),
    .is_load  (ld_vec),
    .hit      (hit_a),
    .slot_idx (idx_a),
    .hit_load (ld_a)
  );

  hazard_operand_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .RW        (RW),
    .SW        (SW)
  ) u_match_b (
    .use_src  (dec_use_b),
    .src      (dec_rs_b),
    .cand     (cand),
    .rd       (rd_vec),
    .is_load  (ld_vec),
    .hit      (hit_b),
    .slot_idx (idx_b),
    .hit_load (ld_b)
  );

  // Without bypass the register file has
  // no write-through, so even a writeback
  // producer blocks the reader.
  always_comb begin
    raw_stall = 1'b0;
    fwd_sel_a = SW'(FWD_RF);
    fwd_sel_b = SW'(FWD_RF);
    if (FWD_EN != 0) begin
      fwd_sel_a = idx_a;
      fwd_sel_b = idx_b;
      raw_stall =
        (hit_a && ld_a &&
         int'(idx_a) < LOAD_READY_SLOT) ||
        (hit_b && ld_b &&
         int'(idx_b) < LOAD_READY_SLOT);
    end else begin
      raw_stall = hit_a || hit_b;
    end
  end

  assign nz_stall = dec_rd_nz &&
                    |(nz_vec & nz_mask);

  assign stall  = dec_valid && !flush &&
                  (raw_stall || nz_stall);
  assign bubble = stall || flush;
  assign issue  = dec_valid && !stall &&
                  !flush;

  always_comb begin
    dec_entry         = '0;
    dec_entry.valid   = 1'b1;
    dec_entry.rd      = HZ_RW_MAX'(dec_rd);
    dec_entry.wr_reg  = dec_wr_reg;
    dec_entry.is_load = dec_is_load;
    dec_entry.wr_nz   = dec_wr_nz;
  end

  always_comb begin
    slot_d    = slot_q;
    slot_d[1] = issue ? dec_entry : '0;
    for (int k = 2; k <= NUM_SLOTS; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q +
                      CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q        <= '0;
      stall_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: u_fwd uses bypass defaults, u_nof has
// FWD_EN=0 with a 4-bit counter for saturation.
module tb_pipeline_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs_a;
    logic [2:0] rs_b;
    logic       use_a;
    logic       use_b;
    logic [2:0] rd;
    logic       wr_reg;
    logic       is_load;
    logic       wr_nz;
    logic       rd_nz;
    logic       flush;
  } dec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  dec_t i0 = '0;
  dec_t i1 = '0;

  logic        st0, bu0, st1, bu1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit u_fwd (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (i0.valid),
    .dec_rs_a    (i0.rs_a),
    .dec_rs_b    (i0.rs_b),
    .dec_use_a   (i0.use_a),
    .dec_use_b   (i0.use_b),
    .dec_rd      (i0.rd),
    .dec_wr_reg  (i0.wr_reg),
    .dec_is_load (i0.is_load),
    .dec_wr_nz   (i0.wr_nz),
    .dec_rd_nz   (i0.rd_nz),
    .flush       (i0.flush),
    .stall       (st0),
    .bubble      (bu0),
    .fwd_sel_a   (fa0),
    .fwd_sel_b   (fb0),
    .stall_count (cnt0)
  );

  pipeline_hazard_unit #(
    .FWD_EN (0),
    .CNT_W  (4)
  ) u_nof (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (i1.valid),
    .dec_rs_a    (i1.rs_a),
    .dec_rs_b    (i1.rs_b),
    .dec_use_a   (i1.use_a),
    .dec_use_b   (i1.use_b),
    .dec_rd      (i1.rd),
    .dec_wr_reg  (i1.wr_reg),
    .dec_is_load (i1.is_load),
    .dec_wr_nz   (i1.wr_nz),
    .dec_rd_nz   (i1.rd_nz),
    .flush       (i1.flush),
    .stall       (st1),
    .bubble      (bu1),
    .fwd_sel_a   (fa1),
    .fwd_sel_b   (fb1),
    .stall_count (cnt1)
  );

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d",
                  tag, got, exp);
  endtask

  task automatic obs0(
    input string tag,
    input int st, input int bu,
    input int fa, input int fb
  );
    chk({tag, ".stall"},  st0, st);
    chk({tag, ".bubble"}, bu0, bu);
    chk({tag, ".fwd_a"},  fa0, fa);
    chk({tag, ".fwd_b"},  fb0, fb);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic dec_t mk(
    input logic [2:0] rd,  input logic wr,
    input logic [2:0] ra,  input logic ua,
    input logic [2:0] rb,  input logic ub,
    input logic ld, input logic wnz,
    input logic rnz
  );
    dec_t d;
    d         = '0;
    d.valid   = 1'b1;
    d.rd      = rd;
    d.wr_reg  = wr;
    d.rs_a    = ra;
    d.use_a   = ua;
    d.rs_b    = rb;
    d.use_b   = ub;
    d.is_load = ld;
    d.wr_nz   = wnz;
    d.rd_nz   = rnz;
    return d;
  endfunction

  // mv r2,r1 then add r3,r2: three stall
  // cycles, issue, then drain.
  task automatic hazard1(input string tag);
    i1 = mk(3'd2, 1, 3'd1, 1, 3'd0, 0, 0, 0, 0);
    tick;
    i1 = mk(3'd3, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk({tag, ".stall"}, st1, 1);
      chk({tag, ".fwd_a"}, fa1, 0);
      tick;
    end
    #1;
    chk({tag, ".issue"}, st1, 0);
    chk({tag, ".fwd_b"}, fb1, 0);
    tick;
    i1 = '0;
    tick; tick; tick;
  endtask

  initial begin
    i0 = mk(3'd1, 1, 3'd1, 1, 3'd2, 1, 0, 0, 1);
    #2;
    obs0("rst0", 0, 0, 0, 0);
    chk("rst0.cnt",   cnt0, 0);
    chk("rst1.stall", st1, 0);
    chk("rst1.cnt",   cnt1, 0);
    i0 = '0;
    tick;
    reset = 1'b1;
    tick;

    // add r1,r2 ; sub r3,r1 ; reader of r1,r3
    i0 = mk(3'd1, 1, 3'd1, 1, 3'd2, 1, 0, 0, 0);
    #1 obs0("t1.add", 0, 0, 0, 0);
    tick;
    i0 = mk(3'd3, 1, 3'd1, 1, 3'd3, 1, 0, 0, 0);
    #1 obs0("t1.sub", 0, 0, 1, 0);
    tick;
    i0 = mk(3'd5, 1, 3'd1, 1, 3'd3, 1, 0, 0, 0);
    #1 obs0("t1.rd3", 0, 0, 2, 1);
    tick;
    i0 = '0;
    tick; tick; tick;

    // ld r4,[r5] ; add r6,r4
    i0 = mk(3'd4, 1, 3'd5, 1, 3'd0, 0, 1, 0, 0);
    #1 obs0("t2.ld", 0, 0, 0, 0);
    tick;
    i0 = mk(3'd6, 1, 3'd4, 1, 3'd6, 1, 0, 0, 0);
    #1;
    chk("t2.stall",  st0, 1);
    chk("t2.bubble", bu0, 1);
    tick;
    #1 obs0("t2.go", 0, 0, 2, 0);
    chk("t2.cnt", cnt0, 1);
    tick;
    i0 = '0;
    tick; tick; tick;

    // cmp r1,r2 ; branch on NZ
    i0 = mk(3'd0, 0, 3'd1, 1, 3'd2, 1, 0, 1, 0);
    tick;
    i0 = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1);
    #1;
    chk("t4.stall",  st0, 1);
    chk("t4.bubble", bu0, 1);
    tick;
    #1 chk("t4.go", st0, 0);
    chk("t4.cnt", cnt0, 2);
    tick;
    i0 = mk(3'd0, 0, 3'd1, 1, 3'd2, 1, 0, 1, 0);
    tick;
    i0 = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0);
    #1 chk("t4.nonz", st0, 0);
    tick;
    i0 = '0;
    tick; tick; tick;

    // load-use hazard coinciding with flush
    i0 = mk(3'd4, 1, 3'd5, 1, 3'd0, 0, 1, 0, 0);
    tick;
    i0 = mk(3'd6, 1, 3'd4, 1, 3'd6, 1, 0, 0, 0);
    i0.flush = 1'b1;
    #1;
    chk("t5.stall",  st0, 0);
    chk("t5.bubble", bu0, 1);
    tick;
    i0 = mk(3'd7, 1, 3'd6, 1, 3'd4, 1, 0, 0, 0);
    #1 obs0("t5.after", 0, 0, 0, 2);
    chk("t5.cnt", cnt0, 2);
    tick;
    i0 = '0;
    tick; tick; tick;

    // no-bypass instance
    hazard1("t3");
    chk("t3.cnt", cnt1, 3);
    for (int n = 0; n < 4; n++) hazard1("t6");
    chk("t6.cnt15", cnt1, 15);
    i1 = mk(3'd2, 1, 3'd1, 1, 3'd0, 0, 0, 0, 0);
    tick;
    i1 = mk(3'd3, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0);
    #1 chk("t6.stall", st1, 1);
    tick;
    #1;
    chk("t6.stall2", st1, 1);
    chk("t6.sat",    cnt1, 15);
    reset = 1'b0;
    #1;
    chk("t6.rst.stall",  st1, 0);
    chk("t6.rst.bubble", bu1, 0);
    chk("t6.rst.cnt",    cnt1, 0);
    tick;
    reset = 1'b1;
    #1;
    chk("t6.rel.stall", st1, 0);
    chk("t6.rel.cnt",   cnt1, 0);
    tick;

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
